// File: rtl/pdl_ptr_ctl.sv
// pdl_ptr_ctl
// -----------------------------------------------------------------------------
// PDL pointer/index control stage. Sits after source/destination decode and
// owns the 10-bit PDL pointer and index registers. Writes to the 1024x32 PDL
// RAM are deferred by one cycle: the address and data are captured at advance
// and issued to the RAM in the following cycle (state WRITE). Reads are
// combinational. While a write is pending, a read of the same address returns
// the held write data instead of the stale RAM word.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   advance, nop        instruction-complete strobe; nop suppresses all commits
//   destpdltop          write at pointer
//   destpdl_p           push (write at pointer+1, pointer increments)
//   destpdl_x           write at index
//   destpdlp, destpdlx  load pointer / index from ob[9:0]
//   srcpdltop           read at index
//   srcpdlpop           pop (read at pointer, pointer decrements)
//   srcpdlptr/srcpdlidx read pointer / index value
//   ob                  writeback data, valid with advance
//   pdl_q               RAM read data (combinational from pdla)
//   pdla, pdlwe, pdl_wd RAM address, write enable, write data
//   pdlptr, pdlidx      current pointer and index
//   mf, mf_en           M-function source data and its valid
//   pdl_wrap            sticky: pointer wrapped on push or pop
// -----------------------------------------------------------------------------
module pdl_ptr_ctl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        advance,
  input  logic        nop,
  input  logic        destpdltop,
  input  logic        destpdl_p,
  input  logic        destpdl_x,
  input  logic        destpdlp,
  input  logic        destpdlx,
  input  logic        srcpdltop,
  input  logic        srcpdlpop,
  input  logic        srcpdlptr,
  input  logic        srcpdlidx,
  input  logic [31:0] ob,
  input  logic [31:0] pdl_q,
  output logic [9:0]  pdla,
  output logic        pdlwe,
  output logic [31:0] pdl_wd,
  output logic [9:0]  pdlptr,
  output logic [9:0]  pdlidx,
  output logic [31:0] mf,
  output logic        mf_en,
  output logic        pdl_wrap
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [9:0]  ptr_q, ptr_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wrap_q, wrap_d;

  logic        commit;
  logic        push_pop;
  logic        wr_req;
  logic [9:0]  ptr_inc, ptr_dec;
  logic [9:0]  raddr;
  logic        bypass;

  assign commit   = advance & ~nop;
  // Push and pop in the same instruction replace the top in place.
  assign push_pop = destpdl_p & srcpdlpop;
  assign wr_req   = commit & (destpdl_p | destpdltop | destpdl_x);
  assign ptr_inc  = ptr_q + 10'd1;
  assign ptr_dec  = ptr_q - 10'd1;

  // ---------------------------------------------------------------------------
  // Next-state / deferred write capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = IDLE;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wr_req) begin
      state_d = WRITE;
      wdata_d = ob;
      if (destpdl_p && !srcpdlpop) waddr_d = ptr_inc;
      else if (destpdl_p)          waddr_d = ptr_q;
      else if (destpdltop)         waddr_d = ptr_q;
      else                         waddr_d = idx_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer / index / wrap update
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d  = ptr_q;
    idx_d  = idx_q;
    wrap_d = wrap_q;
    if (commit) begin
      if (destpdlp) begin
        ptr_d = ob[9:0];
      end else if (push_pop) begin
        ptr_d = ptr_q;
      end else if (destpdl_p) begin
        ptr_d = ptr_inc;
        if (ptr_q == 10'h3ff) wrap_d = 1'b1;
      end else if (srcpdlpop) begin
        ptr_d = ptr_dec;
        if (ptr_q == 10'h000) wrap_d = 1'b1;
      end
      if (destpdlx) idx_d = ob[9:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wrap_q  <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port and M-function source
  // ---------------------------------------------------------------------------
  // Read address is formed the same way in both states so the bypass compare
  // sees the address the instruction actually wants.
  assign raddr  = srcpdltop ? idx_q : ptr_q;
  assign bypass = (state_q == WRITE) && (raddr == waddr_q);

  assign pdlwe  = (state_q == WRITE);
  assign pdla   = pdlwe ? waddr_q : raddr;
  assign pdl_wd = wdata_q;

  assign pdlptr   = ptr_q;
  assign pdlidx   = idx_q;
  assign pdl_wrap = wrap_q;

  always_comb begin
    mf_en = ~nop & (srcpdlptr | srcpdlidx | srcpdltop | srcpdlpop);
    mf    = '0;
    if (mf_en) begin
      if (srcpdlptr)      mf = {22'b0, ptr_q};
      else if (srcpdlidx) mf = {22'b0, idx_q};
      else if (bypass)    mf = wdata_q;
      else                mf = pdl_q;
    end
  end

endmodule

// File: tb/tb_pdl_ptr_ctl.sv
module tb_pdl_ptr_ctl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        advance, nop;
  logic        destpdltop, destpdl_p, destpdl_x, destpdlp, destpdlx;
  logic        srcpdltop, srcpdlpop, srcpdlptr, srcpdlidx;
  logic [31:0] ob, pdl_q;
  logic [9:0]  pdla;
  logic        pdlwe;
  logic [31:0] pdl_wd;
  logic [9:0]  pdlptr, pdlidx;
  logic [31:0] mf;
  logic        mf_en, pdl_wrap;

  int pass_cnt = 0;
  int total_cnt = 0;

  pdl_ptr_ctl dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .nop(nop),
    .destpdltop(destpdltop), .destpdl_p(destpdl_p), .destpdl_x(destpdl_x),
    .destpdlp(destpdlp), .destpdlx(destpdlx),
    .srcpdltop(srcpdltop), .srcpdlpop(srcpdlpop), .srcpdlptr(srcpdlptr),
    .srcpdlidx(srcpdlidx), .ob(ob), .pdl_q(pdl_q),
    .pdla(pdla), .pdlwe(pdlwe), .pdl_wd(pdl_wd), .pdlptr(pdlptr),
    .pdlidx(pdlidx), .mf(mf), .mf_en(mf_en), .pdl_wrap(pdl_wrap)
  );

  always #5 clk = ~clk;

  task automatic clr();
    advance = 0; nop = 0;
    destpdltop = 0; destpdl_p = 0; destpdl_x = 0; destpdlp = 0; destpdlx = 0;
    srcpdltop = 0; srcpdlpop = 0; srcpdlptr = 0; srcpdlidx = 0;
    ob = '0; pdl_q = '0;
  endtask

  // Advance to 1 time unit after the next rising edge, then drop strobes.
  task automatic tick();
    @(posedge clk); #1;
    clr();
    #1;
  endtask

  task automatic test_reset();
    clr();
    reset_n = 0;
    #12;
    total_cnt++; if (pdlptr !== 10'h0) $display("FAIL rst_ptr got %h want 000", pdlptr); else pass_cnt++;
    total_cnt++; if (pdlidx !== 10'h0) $display("FAIL rst_idx got %h want 000", pdlidx); else pass_cnt++;
    total_cnt++; if (pdlwe !== 1'b0) $display("FAIL rst_we got %b want 0", pdlwe); else pass_cnt++;
    total_cnt++; if (pdla !== 10'h0) $display("FAIL rst_pdla got %h want 000", pdla); else pass_cnt++;
    total_cnt++; if (pdl_wd !== 32'h0) $display("FAIL rst_wd got %h want 0", pdl_wd); else pass_cnt++;
    total_cnt++; if (pdl_wrap !== 1'b0) $display("FAIL rst_wrap got %b want 0", pdl_wrap); else pass_cnt++;
    total_cnt++; if (mf !== 32'h0 || mf_en !== 1'b0) $display("FAIL rst_mf got %h/%b want 0/0", mf, mf_en); else pass_cnt++;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #2;
  endtask

  task automatic test_push();
    destpdl_p = 1; ob = 32'hDEADBEEF; advance = 1;
    tick();
    total_cnt++; if (pdla !== 10'h1) $display("FAIL push_pdla got %h want 001", pdla); else pass_cnt++;
    total_cnt++; if (pdlwe !== 1'b1) $display("FAIL push_we got %b want 1", pdlwe); else pass_cnt++;
    total_cnt++; if (pdl_wd !== 32'hDEADBEEF) $display("FAIL push_wd got %h want deadbeef", pdl_wd); else pass_cnt++;
    total_cnt++; if (pdlptr !== 10'h1) $display("FAIL push_ptr got %h want 001", pdlptr); else pass_cnt++;
    tick();
    total_cnt++; if (pdlwe !== 1'b0) $display("FAIL push_we_once got %b want 0", pdlwe); else pass_cnt++;
  endtask

  task automatic test_wrap();
    destpdlp = 1; ob = 32'h3FF; advance = 1;
    tick();
    total_cnt++; if (pdlptr !== 10'h3FF) $display("FAIL load_ptr got %h want 3ff", pdlptr); else pass_cnt++;
    total_cnt++; if (pdlwe !== 1'b0 || pdl_wrap !== 1'b0) $display("FAIL load_nowr got we=%b wrap=%b want 0/0", pdlwe, pdl_wrap); else pass_cnt++;
    destpdl_p = 1; ob = 32'h55; advance = 1;
    tick();
    total_cnt++; if (pdlptr !== 10'h0) $display("FAIL wrap_ptr got %h want 000", pdlptr); else pass_cnt++;
    total_cnt++; if (pdla !== 10'h0 || pdlwe !== 1'b1) $display("FAIL wrap_wr got a=%h we=%b want 000/1", pdla, pdlwe); else pass_cnt++;
    total_cnt++; if (pdl_wrap !== 1'b1) $display("FAIL wrap_flag got %b want 1", pdl_wrap); else pass_cnt++;
    tick();
    srcpdlpop = 1; advance = 1; pdl_q = 32'h0BAD0BAD;
    #1;
    total_cnt++; if (mf !== 32'h0BAD0BAD || mf_en !== 1'b1) $display("FAIL pop0_mf got %h/%b want 0bad0bad/1", mf, mf_en); else pass_cnt++;
    tick();
    total_cnt++; if (pdlptr !== 10'h3FF) $display("FAIL pop_wrap_ptr got %h want 3ff", pdlptr); else pass_cnt++;
    total_cnt++; if (pdl_wrap !== 1'b1) $display("FAIL wrap_sticky got %b want 1", pdl_wrap); else pass_cnt++;
  endtask

  task automatic test_bypass();
    destpdlp = 1; ob = 32'h5; advance = 1;
    tick();
    destpdl_p = 1; ob = 32'h12345678; advance = 1;
    tick();
    srcpdlpop = 1; advance = 1; pdl_q = 32'h0;
    #1;
    total_cnt++; if (mf !== 32'h12345678) $display("FAIL byp_mf got %h want 12345678", mf); else pass_cnt++;
    total_cnt++; if (mf_en !== 1'b1 || pdla !== 10'h6) $display("FAIL byp_port got en=%b a=%h want 1/006", mf_en, pdla); else pass_cnt++;
    tick();
    total_cnt++; if (pdlptr !== 10'h5) $display("FAIL byp_ptr got %h want 005", pdlptr); else pass_cnt++;
  endtask

  task automatic test_push_pop();
    destpdlp = 1; ob = 32'h7; advance = 1;
    tick();
    destpdl_p = 1; srcpdlpop = 1; ob = 32'hA5; advance = 1;
    tick();
    total_cnt++; if (pdlptr !== 10'h7) $display("FAIL pp_ptr got %h want 007", pdlptr); else pass_cnt++;
    total_cnt++; if (pdla !== 10'h7 || pdlwe !== 1'b1 || pdl_wd !== 32'hA5) $display("FAIL pp_wr got a=%h we=%b d=%h want 007/1/a5", pdla, pdlwe, pdl_wd); else pass_cnt++;
    destpdlp = 1; srcpdlpop = 1; ob = 32'h40; advance = 1;
    tick();
    total_cnt++; if (pdlptr !== 10'h40) $display("FAIL ldpop_ptr got %h want 040", pdlptr); else pass_cnt++;
  endtask

  task automatic test_index();
    destpdlx = 1; ob = 32'h2A; advance = 1;
    tick();
    total_cnt++; if (pdlidx !== 10'h2A || pdlwe !== 1'b0) $display("FAIL ldx got idx=%h we=%b want 02a/0", pdlidx, pdlwe); else pass_cnt++;
    srcpdltop = 1; pdl_q = 32'hCAFEF00D;
    #1;
    total_cnt++; if (pdla !== 10'h2A) $display("FAIL top_pdla got %h want 02a", pdla); else pass_cnt++;
    total_cnt++; if (mf !== 32'hCAFEF00D || mf_en !== 1'b1) $display("FAIL top_mf got %h/%b want cafef00d/1", mf, mf_en); else pass_cnt++;
    srcpdltop = 0; srcpdlidx = 1;
    #1;
    total_cnt++; if (mf !== 32'h2A || mf_en !== 1'b1) $display("FAIL idx_mf got %h/%b want 0000002a/1", mf, mf_en); else pass_cnt++;
    srcpdlptr = 1;
    #1;
    total_cnt++; if (mf !== 32'h40) $display("FAIL ptr_prio got %h want 00000040", mf); else pass_cnt++;
    clr();
    #1;
    total_cnt++; if (mf !== 32'h0 || mf_en !== 1'b0) $display("FAIL nosrc_mf got %h/%b want 0/0", mf, mf_en); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    destpdl_x = 1; ob = 32'h77; advance = 1;
    tick();
    total_cnt++; if (pdla !== 10'h2A || pdlwe !== 1'b1 || pdl_wd !== 32'h77) $display("FAIL wrx got a=%h we=%b d=%h want 02a/1/77", pdla, pdlwe, pdl_wd); else pass_cnt++;
    destpdl_p = 1; ob = 32'h11; advance = 1;
    tick();
    total_cnt++; if (pdla !== 10'h41 || pdlwe !== 1'b1 || pdl_wd !== 32'h11) $display("FAIL b2b got a=%h we=%b d=%h want 041/1/11", pdla, pdlwe, pdl_wd); else pass_cnt++;
    total_cnt++; if (pdlptr !== 10'h41) $display("FAIL b2b_ptr got %h want 041", pdlptr); else pass_cnt++;
    tick();
    total_cnt++; if (pdlwe !== 1'b0) $display("FAIL b2b_idle got %b want 0", pdlwe); else pass_cnt++;
  endtask

  task automatic test_nop();
    nop = 1; destpdl_p = 1; srcpdlptr = 1; ob = 32'h99; advance = 1;
    #1;
    total_cnt++; if (mf_en !== 1'b0 || mf !== 32'h0) $display("FAIL nop_mf got %h/%b want 0/0", mf, mf_en); else pass_cnt++;
    tick();
    total_cnt++; if (pdlptr !== 10'h41 || pdlwe !== 1'b0) $display("FAIL nop_commit got ptr=%h we=%b want 041/0", pdlptr, pdlwe); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    destpdl_p = 1; ob = 32'h1; advance = 1;
    tick();
    total_cnt++; if (pdlwe !== 1'b1) $display("FAIL mid_pre got %b want 1", pdlwe); else pass_cnt++;
    reset_n = 0;
    #1;
    total_cnt++; if (pdlwe !== 1'b0 || pdlptr !== 10'h0) $display("FAIL mid_rst got we=%b ptr=%h want 0/000", pdlwe, pdlptr); else pass_cnt++;
    total_cnt++; if (pdl_wrap !== 1'b0 || pdlidx !== 10'h0) $display("FAIL mid_rst_st got wrap=%b idx=%h want 0/000", pdl_wrap, pdlidx); else pass_cnt++;
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #2;
  endtask

  initial begin
    test_reset();
    test_push();
    test_wrap();
    test_bypass();
    test_push_pop();
    test_index();
    test_back_to_back();
    test_nop();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pdl_ptr_ctl.md
# pdl_ptr_ctl

PDL buffer pointer/index control stage, directly downstream of the source/destination decode. It consumes the decoded PDL strobes (push, pop, pointer/index loads, pointer- and index-addressed accesses) and maintains the 10-bit PDL pointer and index registers. It drives the 1024×32 PDL RAM address and write enable with a one-cycle deferred write, and returns PDL data and pointer/index values to the M-function bus with write-to-read bypass.

## Interface
Parameters:
- none (PDL depth fixed at 1024, pointer/index width 10, data width 32)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- advance  in  1  one-cycle strobe at instruction completion; commits decoded effects
- nop  in  1  current instruction is a no-op; suppresses every commit at advance
- destpdltop, destpdl_p, destpdl_x, destpdlp, destpdlx  in  1 each  decoded destinations: write at pointer, push, write at index, load pointer, load index
- srcpdltop, srcpdlpop, srcpdlptr, srcpdlidx  in  1 each  decoded sources: read at index, pop, read pointer, read index
- ob  in  32  writeback data, valid in the cycle advance is high
- pdl_q  in  32  PDL RAM read data, combinational from pdla
- pdla  out  10  PDL RAM address
- pdlwe  out  1  PDL RAM write enable
- pdl_wd  out  32  PDL RAM write data
- pdlptr, pdlidx  out  10 each  current pointer and index
- mf  out  32  M-function source data
- mf_en  out  1  mf is valid, meaning one of the four src strobes is active and nop is low
- pdl_wrap  out  1  sticky flag, set on a pointer wrap caused by push or pop

## Operation
State machine has two states:
- IDLE: no write pending.
- WRITE: one deferred write pending.
- At advance with nop low, the block performs one of the writes below, latches ob into the write-data register and the target address into waddr, and enters WRITE. Otherwise, at advance, the state returns to IDLE.
  - destpdl_p: write at pdlptr+1.
  - destpdltop: write at pdlptr.
  - destpdl_x: write at pdlidx.

Pointer update at advance (nop low), in priority order:
- destpdlp: pdlptr ← ob[9:0].
- srcpdlpop and destpdl_p together: pointer unchanged; write address is pdlptr, replacing the top.
- destpdl_p alone: pdlptr ← pdlptr+1 mod 1024.
- srcpdlpop alone: pdlptr ← pdlptr−1 mod 1024.

Other updates at advance:
- destpdlx: pdlidx ← ob[9:0]. Index is never auto-modified.
- pdl_wrap is set by an increment from 1023 to 0 or a decrement from 0 to 1023. It is cleared only by reset.

Address mux:
- In WRITE: pdla = waddr, pdlwe = 1, pdl_wd = latched data.
- Otherwise: pdla = pdlidx if srcpdltop, else pdlptr. pdlwe = 0.

mf source, in priority order:
- srcpdlptr: {22'b0, pdlptr}.
- srcpdlidx: {22'b0, pdlidx}.
- srcpdltop or srcpdlpop: PDL data. The block substitutes the latched write data when a write is pending to the same address; otherwise it passes pdl_q. In WRITE, the read address is computed as in IDLE and compared with waddr.
- No src strobe active: mf = 0, mf_en = 0.

## Timing
- Reset values: pdlptr=0, pdlidx=0, state IDLE, pdlwe=0, pdla=0, pdl_wd=0, pdl_wrap=0, mf=0, mf_en=0.
- Pointer and index registers update on the advance edge, so new values are visible the next cycle.
- RAM write occurs exactly one cycle after advance; pdlwe is high for one cycle.
- Back-to-back advance: the pending write issues in the same cycle a new write is latched. The state stays WRITE and no write is lost.
- A read issued in the WRITE cycle while a write is pending is bypassed. Effective read latency is 0 cycles, with combinational mf.
- Reset asserted mid-WRITE discards the pending write. pdlwe drops asynchronously.

## Test plan
- Reset, then push 0xDEADBEEF with advance → next cycle pdla=1, pdlwe=1, pdl_wd=0xDEADBEEF; pdlptr=1.
- Load pdlptr=1023 via destpdlp with ob=0x3FF, then push → pdlptr=0, write at address 0, pdl_wrap=1. From pdlptr=0, a pop → pdlptr=1023.
- Push 0x12345678 at pdlptr=5, then pop in the very next instruction (WRITE cycle) → mf=0x12345678 from bypass even though pdl_q=0; pdlptr returns to 5.
- Push and pop together at pdlptr=7 → pdlptr stays 7, write at 7. destpdlp together with srcpdlpop, ob=0x040 → pdlptr=0x040.
- destpdlx with ob=0x2A, then srcpdltop → pdla=0x2A, mf=pdl_q. srcpdlidx → mf=0x0000002A, mf_en=1.
- Push with nop=1 → no pointer change, pdlwe stays 0. Assert reset_n=0 during WRITE → pdlwe=0 immediately, pdlptr=0.
